// File: rtl/ramarb2.sv
// Port-1 sequencer/arbiter for a dual-port RAM: clears every word after reset or on clr_i,
// then shares the write/read port between two masters with round-robin priority.
module ramarb2 #(
    parameter int SZ = 2,
    parameter int DW = 32,
    localparam int AW = (SZ > 1) ? $clog2(SZ) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    output logic          init_done_o,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_data_i,
    output logic          m0_rdy_o,
    output logic [DW-1:0] m0_data_o,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_data_i,
    output logic          m1_rdy_o,
    output logic [DW-1:0] m1_data_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_data_o,
    input  logic [DW-1:0] ram_data_i
);
    typedef enum logic {INIT, RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          lst_q, lst_d;
    logic          done_q, done_d;
    logic          g0, g1, we;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
            lst_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lst_q   <= lst_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lst_d      = lst_q;
        done_d     = done_q;
        g0         = 1'b0;
        g1         = 1'b0;
        we         = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        case (state_q)
            INIT: begin
                we         = 1'b1;
                ram_addr_o = cnt_q;
                if (cnt_q == AW'(SZ - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (clr_i) begin
                    state_d = INIT;
                    done_d  = 1'b0;
                end else begin
                    // lst_q=1 means m1 won last time, so m0 wins a tie
                    g0 = m0_stb_i && (!m1_stb_i || lst_q);
                    g1 = m1_stb_i && (!m0_stb_i || !lst_q);
                    if (g0) begin
                        we         = m0_we_i;
                        ram_addr_o = m0_addr_i;
                        ram_data_o = m0_data_i;
                        lst_d      = 1'b0;
                    end else if (g1) begin
                        we         = m1_we_i;
                        ram_addr_o = m1_addr_i;
                        ram_data_o = m1_data_i;
                        lst_d      = 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    assign ram_we_o    = we && !rst_i;
    assign m0_rdy_o    = g0 && !rst_i;
    assign m1_rdy_o    = g1 && !rst_i;
    assign init_done_o = done_q && !rst_i;
    assign m0_data_o   = ram_data_i;
    assign m1_data_o   = ram_data_i;
endmodule

// File: tb/tb_ramarb2.sv
// Bench for ramarb2 (SZ=8): directed scenarios then random traffic, each cycle checked
// against a transaction-level model of the clear sequence, round-robin and RAM contents.
module tb_ramarb2;
    localparam int SZ = 8;
    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst, clr;
    logic          init_done;
    logic          m0_stb, m0_we, m1_stb, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wd, m1_wd, m0_rd, m1_rd;
    logic          m0_rdy, m1_rdy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wd, ram_rd;

    logic [DW-1:0] ram [SZ];

    int tests = 0;
    int fails = 0;

    // reference model state
    bit            m_run = 0;
    int            m_pos = 0;
    int            m_last = 1;
    logic [DW-1:0] exp_mem [SZ];

    always #5 clk = ~clk;

    ramarb2 #(.SZ(SZ), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .init_done_o(init_done),
        .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_data_i(m0_wd),
        .m0_rdy_o(m0_rdy), .m0_data_o(m0_rd),
        .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_data_i(m1_wd),
        .m1_rdy_o(m1_rdy), .m1_data_o(m1_rd),
        .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_wd), .ram_data_i(ram_rd)
    );

    // RAM port 1: synchronous write, asynchronous read
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wd;
    assign ram_rd = ram[ram_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic cyc();
        int            g;
        logic          gwe;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        g = -1; gwe = 0; ga = '0; gd = '0;
        #2;
        if (rst) begin
            chk("rst_we", ram_we, 0);
            chk("rst_rdy0", m0_rdy, 0);
            chk("rst_rdy1", m1_rdy, 0);
            chk("rst_done", init_done, 0);
        end else if (!m_run) begin
            chk("init_done", init_done, 0);
            chk("init_we", ram_we, 1);
            chk("init_addr", ram_addr, m_pos);
            chk("init_data", ram_wd, 0);
            chk("init_rdy0", m0_rdy, 0);
            chk("init_rdy1", m1_rdy, 0);
        end else begin
            chk("run_done", init_done, 1);
            if (clr)                  g = -1;
            else if (m0_stb && m1_stb) g = 1 - m_last;
            else if (m0_stb)          g = 0;
            else if (m1_stb)          g = 1;
            if (g == 0) begin gwe = m0_we; ga = m0_addr; gd = m0_wd; end
            if (g == 1) begin gwe = m1_we; ga = m1_addr; gd = m1_wd; end
            chk("rdy0", m0_rdy, g == 0);
            chk("rdy1", m1_rdy, g == 1);
            chk("we", ram_we, (g >= 0) && gwe);
            if (g >= 0) begin
                chk("addr", ram_addr, ga);
                if (gwe) chk("wdata", ram_wd, gd);
                else begin
                    chk("rd0", m0_rd, exp_mem[ga]);
                    chk("rd1", m1_rd, exp_mem[ga]);
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            m_run = 0; m_pos = 0; m_last = 1;
        end else if (!m_run) begin
            exp_mem[m_pos] = '0;
            m_pos++;
            if (m_pos == SZ) begin m_run = 1; m_pos = 0; end
        end else if (clr) begin
            m_run = 0; m_pos = 0;
        end else if (g >= 0) begin
            if (gwe) exp_mem[ga] = gd;
            m_last = g;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        clr = 0; m0_stb = 0; m1_stb = 0; m0_we = 0; m1_we = 0;
        m0_addr = '0; m1_addr = '0; m0_wd = '0; m1_wd = '0;
    endtask

    task automatic do_reset();
        rst = 1; cyc(); cyc(); rst = 0;
    endtask

    initial begin
        rst = 1; idle();
        @(negedge clk);
        do_reset();

        // m0 requests throughout the clear; no grant until RUN
        m0_stb = 1; m0_we = 0; m0_addr = 3'd1;
        repeat (SZ) cyc();
        idle();

        // m0 writes, m1 reads same address next cycle
        m0_stb = 1; m0_we = 1; m0_addr = 3'd3; m0_wd = 32'hDEADBEEF; cyc();
        idle(); m1_stb = 1; m1_addr = 3'd3; #2;
        chk("wr_then_rd", m1_rd, 32'hDEADBEEF);
        chk("wr_then_rd_rdy", m1_rdy, 1);
        @(negedge clk);
        idle();

        // contention right after reset: m0 first, then alternating
        do_reset(); repeat (SZ) cyc();
        m0_stb = 1; m1_stb = 1; m0_addr = 3'd2; m1_addr = 3'd6;
        repeat (6) cyc();
        idle();

        // solo m1 grants then contention goes to m0
        do_reset(); repeat (SZ) cyc();
        m1_stb = 1; m1_addr = 3'd4; repeat (3) cyc();
        m0_stb = 1; #2;
        chk("rr_after_solo", m0_rdy, 1);
        @(negedge clk);
        idle();

        // writes, clear pulse, then reads return zero
        m0_stb = 1; m0_we = 1; m0_addr = 3'd2; m0_wd = 32'h1234_5678; cyc();
        m0_addr = 3'd5; m0_wd = 32'hCAFE_F00D; m1_stb = 1; cyc();
        idle(); clr = 1; m0_stb = 1; cyc();
        clr = 0; repeat (SZ) cyc();
        idle(); m0_stb = 1; m0_addr = 3'd2; cyc();
        m0_addr = 3'd5; cyc();
        idle();

        // reset in the middle of the clear
        do_reset(); repeat (4) cyc();
        do_reset(); repeat (SZ + 2) cyc();

        // random traffic
        for (int i = 0; i < 500; i++) begin
            rst     = ($urandom_range(0, 79) == 0);
            clr     = ($urandom_range(0, 29) == 0);
            m0_stb  = $urandom_range(0, 1);
            m1_stb  = $urandom_range(0, 1);
            m0_we   = $urandom_range(0, 1);
            m1_we   = $urandom_range(0, 1);
            m0_addr = AW'($urandom_range(0, SZ - 1));
            m1_addr = AW'($urandom_range(0, SZ - 1));
            m0_wd   = $urandom;
            m1_wd   = $urandom;
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
